// File: rtl/password_checker_pkg.sv
// Shared definitions for the password checker: FSM states, the lowercase
// ASCII bounds of the generator alphabet and the default sizes.
package password_checker_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEARCH    = 2'd1,
        FOUND     = 2'd2,
        EXHAUSTED = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;

    localparam int DEFAULT_NUM_LETTERS = 4;
    localparam int DEFAULT_ATTEMPT_W   = 24;

endpackage

// File: rtl/password_checker_letter_range_check.sv
// Per-byte range check: flags a byte that is not a lowercase letter 'a'..'z'.
module letter_range_check
    import password_checker_pkg::*;
(
    input  logic [7:0] letter,
    output logic       out_of_range
);

    // Purely combinational; one instance per candidate byte.
    always_comb begin
        out_of_range = (letter < ASCII_LOWER_A) || (letter > ASCII_LOWER_Z);
    end

endmodule

// File: rtl/password_checker.sv
// Password checker: consumes candidate words from the brute-force generator
// over a valid/ready handshake, compares each against a loaded target,
// counts attempts and reports found / exhausted.
// Optional macro CASE_FOLD_EN: uppercase target letters are folded to
// lowercase when the target is loaded.
module password_checker
    import password_checker_pkg::*;
#(
    parameter int NUM_LETTERS = DEFAULT_NUM_LETTERS,
    parameter int ATTEMPT_W   = DEFAULT_ATTEMPT_W
)
(
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       load_target,
    input  logic [8*NUM_LETTERS-1:0]   target_word,
    input  logic                       start,
    input  logic [8*NUM_LETTERS-1:0]   cand_word,
    input  logic                       cand_valid,
    input  logic                       cand_last,
    output logic                       cand_ready,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [8*NUM_LETTERS-1:0]   found_word,
    output logic [ATTEMPT_W-1:0]       attempts,
    output logic                       bad_letter
);

    localparam int WORD_W = 8 * NUM_LETTERS;

    // Attempt counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ATTEMPT_W-1:0] sat_inc(input logic [ATTEMPT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + ATTEMPT_W'(1);
    endfunction

    // Target conditioning applied at load time.
    function automatic logic [WORD_W-1:0] fold_target(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = w;
`ifdef CASE_FOLD_EN
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (r[8*i +: 8] >= ASCII_UPPER_A && r[8*i +: 8] <= ASCII_UPPER_Z) begin
                r[8*i + 5] = 1'b1;
            end
        end
`endif
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   target_q, target_d;
    logic                cand_ready_q, cand_ready_d;
    logic                busy_q, busy_d;
    logic                found_q, found_d;
    logic                exhausted_q, exhausted_d;
    logic [WORD_W-1:0]   found_word_q, found_word_d;
    logic [ATTEMPT_W-1:0] attempts_q, attempts_d;
    logic                bad_letter_q, bad_letter_d;

    logic [NUM_LETTERS-1:0] byte_bad;
    logic                   accept;
    logic                   is_match;

    for (genvar g = 0; g < NUM_LETTERS; g++) begin : g_range
        letter_range_check u_range (
            .letter       (cand_word[8*g +: 8]),
            .out_of_range (byte_bad[g])
        );
    end

    // Next-state and next-output logic for the search FSM.
    always_comb begin
        accept   = cand_valid && cand_ready_q;
        is_match = (cand_word == target_q);

        state_d      = state_q;
        target_d     = target_q;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        found_word_d = found_word_q;
        attempts_d   = attempts_q;
        bad_letter_d = bad_letter_q;

        case (state_q)
            IDLE, FOUND, EXHAUSTED: begin
                // A simultaneous load and start captures the new target on
                // this edge, so the search already compares against it.
                if (load_target) begin
                    target_d = fold_target(target_word);
                end
                if (start) begin
                    state_d      = SEARCH;
                    attempts_d   = '0;
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    found_word_d = '0;
                    bad_letter_d = 1'b0;
                end
            end
            SEARCH: begin
                if (accept) begin
                    attempts_d = sat_inc(attempts_q);
                    if (|byte_bad) begin
                        bad_letter_d = 1'b1;
                    end
                    // A match on the final candidate still counts as found.
                    if (is_match) begin
                        state_d      = FOUND;
                        found_d      = 1'b1;
                        found_word_d = cand_word;
                    end else if (cand_last) begin
                        state_d     = EXHAUSTED;
                        exhausted_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cand_ready_d = (state_d == SEARCH);
        busy_d       = (state_d == SEARCH);
    end

    // State and registered outputs; reset also clears the stored target.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            cand_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            found_word_q <= '0;
            attempts_q   <= '0;
            bad_letter_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            cand_ready_q <= cand_ready_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            found_word_q <= found_word_d;
            attempts_q   <= attempts_d;
            bad_letter_q <= bad_letter_d;
        end
    end

    assign cand_ready = cand_ready_q;
    assign busy       = busy_q;
    assign found      = found_q;
    assign exhausted  = exhausted_q;
    assign found_word = found_word_q;
    assign attempts   = attempts_q;
    assign bad_letter = bad_letter_q;

endmodule

// File: tb/tb_password_checker.sv
// Scoreboard bench for password_checker: the driver updates a word-level
// reference model on each accepted candidate and queues the expected
// outcome; a monitor pops and compares when found/exhausted rises.
module tb_password_checker;

    localparam int NL = 4;
    localparam int AW = 24;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          load_target = 1'b0;
    logic [31:0]   target_word = '0;
    logic          start = 1'b0;
    logic [31:0]   cand_word = '0;
    logic          cand_valid = 1'b0;
    logic          cand_last = 1'b0;
    logic          cand_ready, busy, found, exhausted, bad_letter;
    logic [31:0]   found_word;
    logic [AW-1:0] attempts;

    password_checker #(.NUM_LETTERS(NL), .ATTEMPT_W(AW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_target (load_target),
        .target_word (target_word),
        .start       (start),
        .cand_word   (cand_word),
        .cand_valid  (cand_valid),
        .cand_last   (cand_last),
        .cand_ready  (cand_ready),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .found_word  (found_word),
        .attempts    (attempts),
        .bad_letter  (bad_letter)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        f;
        logic        x;
        logic [31:0] w;
        int          att;
        logic        bad;
        int          ncyc;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_err = 0;
    int ncnt = 0;

    // Reference model state
    logic [31:0] m_target = '0;
    int          m_attempts = 0;
    bit          m_bad = 0;
    bit          m_active = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_fold(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef CASE_FOLD_EN
        for (int i = 0; i < 4; i++) begin
            if (r[8*i +: 8] >= 8'd65 && r[8*i +: 8] <= 8'd90)
                r[8*i +: 8] = r[8*i +: 8] + 8'd32;
        end
`endif
        return r;
    endfunction

    function automatic bit m_is_bad(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            if (w[8*i +: 8] < 8'd97 || w[8*i +: 8] > 8'd122) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] idx_to_word(input int i);
        return {8'(97 + (i / 17576) % 26), 8'(97 + (i / 676) % 26),
                8'(97 + (i / 26) % 26), 8'(97 + i % 26)};
    endfunction

    function automatic logic [31:0] rand_lower();
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(97 + $urandom_range(0, 25));
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Control pulse (load and/or start) for one clock, with model update.
    task automatic pulse(input bit ld, input logic [31:0] tw, input bit st);
        load_target = ld;
        target_word = tw;
        start = st;
        tick();
        if (!m_active) begin
            if (ld) m_target = m_fold(tw);
            if (st) begin
                m_attempts = 0;
                m_bad = 0;
                m_active = 1;
            end
        end
        load_target = 1'b0;
        start = 1'b0;
        chk("busy", busy, m_active);
        chk("cand_ready", cand_ready, m_active);
    endtask

    // Offer one candidate and wait for it to be accepted.
    task automatic send(input logic [31:0] w, input bit last);
        int   waited;
        int   n;
        bit   done;
        exp_t e;
        waited = 0;
        done = 0;
        cand_word = w;
        cand_last = last;
        cand_valid = 1'b1;
        while (!done) begin
            @(negedge clock);
            #1;
            if (cand_ready) begin
                n = ncnt;
                tick();
                done = 1;
                if (m_attempts < (1 << AW) - 1) m_attempts++;
                if (m_is_bad(w)) m_bad = 1;
                if (w == m_target || last) begin
                    e.f = (w == m_target);
                    e.x = (w != m_target);
                    e.w = (w == m_target) ? w : 32'h0;
                    e.att = m_attempts;
                    e.bad = m_bad;
                    e.ncyc = n + 1;
                    sb.push_back(e);
                    m_active = 0;
                end
                chk("attempts", attempts, m_attempts);
                chk("bad_letter", bad_letter, m_bad);
            end else if (waited > 50) begin
                n_checks++;
                n_err++;
                $display("FAIL ready_timeout: cand_ready still %0b after %0d cycles", cand_ready, waited);
                tick();
                done = 1;
            end else begin
                waited++;
                tick();
            end
        end
        cand_valid = 1'b0;
        cand_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cand_ready"}, cand_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_exhausted"}, exhausted, 0);
        chk({tag, "_found_word"}, found_word, 0);
        chk({tag, "_attempts"}, attempts, 0);
        chk({tag, "_bad_letter"}, bad_letter, 0);
    endtask

    // Monitor: compare against the scoreboard whenever a result appears.
    exp_t me;
    logic prev_term = 1'b0;
    always @(negedge clock) begin
        ncnt = ncnt + 1;
        if ((found || exhausted) && !prev_term) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: found=%0b exhausted=%0b with nothing expected", found, exhausted);
            end else begin
                me = sb.pop_front();
                chk("sb_found", found, me.f);
                chk("sb_exhausted", exhausted, me.x);
                chk("sb_found_word", found_word, me.w);
                chk("sb_attempts", attempts, me.att);
                chk("sb_bad_letter", bad_letter, me.bad);
                chk("sb_latency", ncnt, me.ncyc);
                chk("sb_ready_low", cand_ready, 0);
            end
        end
        prev_term = found || exhausted;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, tw;
        int          len;

        // Asynchronous reset
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset");
        tick();
        tick();
        reset_n = 1'b1;
        idle(2);

        // Full ordered stream "aaaa".."abcd"
        pulse(1, 32'h61626364, 1);
        for (int i = 0; i < 800 && m_active; i++) send(idx_to_word(i), 0);
        idle(5);
        chk("hold_found", found, 1);
        chk("hold_found_word", found_word, 32'h61626364);
        chk("hold_attempts", attempts, 732);
        chk("hold_ready", cand_ready, 0);

        // Ten non-matching, last ends exhausted
        pulse(1, 32'h7a7a7a7a, 1);
        for (int i = 0; i < 10; i++) begin
            w = rand_lower();
            w[7:0] = 8'(97 + $urandom_range(0, 24));
            send(w, i == 9);
        end
        idle(3);
        chk("exh_level", exhausted, 1);
        chk("exh_found", found, 0);

        // Match together with last
        pulse(1, 32'h61626364, 1);
        send(32'h61626364, 1);
        idle(2);

        // Bad letter, sticky, then match
        pulse(1, 32'h61626364, 1);
        send(32'h61416364, 0);
        send(32'h61616161, 0);
        send(32'h7a7a7a7a, 0);
        send(32'h61626364, 0);
        idle(2);

        // Reset mid-search after five attempts, then restart without reload
        pulse(1, 32'h7a7a7a7a, 1);
        send(32'h61416364, 0);
        for (int i = 0; i < 4; i++) send(32'h61616162 + i, 0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        m_target = '0;
        m_active = 0;
        m_attempts = 0;
        m_bad = 0;
        #1 check_all_zero("midreset");
        tick();
        reset_n = 1'b1;
        tick();
        pulse(0, 32'h0, 1);
        for (int i = 0; i < 6; i++) send(rand_lower(), i == 5);
        idle(2);

        // Uppercase target against lowercase candidate
        pulse(1, 32'h41424344, 1);
        send(32'h61626364, 1);
        idle(2);

        // Randomised rounds with gaps and ignored mid-search controls
        for (int r = 0; r < 15; r++) begin
            tw = rand_lower();
            if ($urandom_range(0, 3) == 0) tw[8*$urandom_range(0, 3) +: 8] = 8'(65 + $urandom_range(0, 25));
            if ($urandom_range(0, 1) == 0) begin
                pulse(1, tw, 1);
            end else begin
                pulse(1, tw, 0);
                pulse(0, 32'h0, 1);
            end
            len = $urandom_range(1, 12);
            for (int k = 0; k < len && m_active; k++) begin
                case ($urandom_range(0, 9))
                    0, 1: w = tw | 32'h20202020;
                    2:    w = $urandom;
                    default: w = rand_lower();
                endcase
                send(w, k == len - 1);
                if (m_active && $urandom_range(0, 5) == 0) pulse(1, rand_lower(), $urandom_range(0, 1));
                idle($urandom_range(0, 2));
            end
            idle(3);
            chk("round_term", found || exhausted, 1);
            chk("round_ready", cand_ready, 0);
            chk("round_busy", busy, 0);
        end

        idle(3);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Consumer end of the brute-force candidate stream.
- Takes NUM_LETTERS-wide ASCII candidate words, assembled from the per-letter lowercase counter chain, over a valid/ready handshake.
- Compares each word against a loaded target word, counts attempts, and reports found or exhausted to the top level (LEDs/UART status).

Parameters:
- NUM_LETTERS, 4, letters per word; first character sits in the most-significant byte.
- ATTEMPT_W, 24, width of the attempt counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- load_target  in  1  one-cycle pulse; capture target_word.
- target_word  in  8*NUM_LETTERS  ASCII target password.
- start  in  1  one-cycle pulse; begin or restart the search.
- cand_word  in  8*NUM_LETTERS  candidate from the generator.
- cand_valid  in  1  candidate present.
- cand_last  in  1  candidate is the final one (generator top-letter wrap).
- cand_ready  out  1  checker accepts this cycle.
- busy  out  1  in SEARCH.
- found  out  1  match reported (level).
- exhausted  out  1  stream ended without a match (level).
- found_word  out  8*NUM_LETTERS  matching candidate.
- attempts  out  ATTEMPT_W  accepted-candidate count.
- bad_letter  out  1  sticky; a candidate byte fell outside 'a'..'z'.

Behaviour:
- Reset (async, reset_n=0): state IDLE; target=0; cand_ready=0; busy=0; found=0; exhausted=0; found_word=0; attempts=0; bad_letter=0.
- States: IDLE, SEARCH, FOUND, EXHAUSTED.
- cand_ready is registered and equals (state==SEARCH).
- Handshake: a candidate is accepted on a rising edge with cand_valid && cand_ready. Generator holds cand_word/cand_last stable until accepted.
- load_target:
  - Honoured in IDLE, FOUND and EXHAUSTED.
  - Ignored in SEARCH; target stays unchanged.
- start:
  - Honoured in IDLE, FOUND and EXHAUSTED. Next state is SEARCH; clears attempts, found, exhausted, found_word and bad_letter.
  - Ignored in SEARCH.
  - If load_target and start occur in the same cycle, the new target is captured; the search starts next cycle using it.
- On acceptance:
  - attempts += 1, saturating at all-ones.
  - Comparison is a full-word equality against the target, computed combinationally and registered.
  - Match: next state FOUND; found=1; found_word=cand_word; cand_ready drops the cycle after acceptance.
  - No match and cand_last=1: next state EXHAUSTED; exhausted=1.
  - Match and cand_last together: FOUND wins; exhausted stays 0.
  - Latency: found/exhausted assert exactly 1 cycle after the accepting edge. No candidate is in flight after that point.
- bad_letter: set if any byte of an accepted candidate is <8'h61 or >8'h7A. The candidate is still counted and compared.
- FOUND and EXHAUSTED are held until start or reset.
- Reset mid-SEARCH returns to IDLE immediately and clears the target. The generator must be re-armed by the top level.

Optional Feature:
- Macro CASE_FOLD_EN.
- Defined: at load_target, each target byte in 'A'..'Z' is stored with bit 5 set (lowercase). Candidate bytes are not folded.
- Undefined: target is stored verbatim; an uppercase target never matches the lowercase generator stream and ends EXHAUSTED.

Decomposition:
- Shared package:
  - state enum (IDLE, SEARCH, FOUND, EXHAUSTED);
  - ASCII_LOWER_A=8'h61 and ASCII_LOWER_Z=8'h7A;
  - default NUM_LETTERS and ATTEMPT_W.
- One sub-module: letter_range_check. It is combinational, per byte, flags bytes outside 'a'..'z', and is instantiated NUM_LETTERS times.
- FSM, counter and compare registers stay in password_checker.

Test Plan:
- Reset then load_target "abcd" (32'h61626364), start; stream "aaaa".."abcd" in order with valid held high -> found=1 one cycle after "abcd" is accepted; found_word=32'h61626364; attempts=732 (0x2DC); cand_ready=0 afterwards.
- Target "zzzz"; stream 10 non-matching candidates, the 10th with cand_last=1 -> exhausted=1, found=0, attempts=10.
- Target "abcd"; single candidate "abcd" with cand_last=1 -> found=1, exhausted=0, attempts=1.
- Candidate 32'h61416364 ("aAcd") accepted -> bad_letter=1 and sticky; attempts increments; no match.
- Pulse reset_n low mid-SEARCH after 5 attempts -> all outputs 0 asynchronously, state IDLE; start without reload -> compares against target 0, nothing matches.
- With CASE_FOLD_EN: load "ABCD", stream "abcd" -> found=1. Without it -> no match; cand_last ends in exhausted=1.
